// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the instruction sequencer
//
// Purpose: opcode and state enumerations, fault codes and the bit positions
// of the fields inside a 32-bit instruction word op | dev | reg | data.
// Ports: none (package).

package seq_pkg;

   typedef enum logic [7:0] {
      OP_NOP   = 8'h00,
      OP_READ  = 8'h01,
      OP_WRITE = 8'h02
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      DECODE,
      ISSUE,
      RESP,
      ADVANCE,
      HALT
   } state_e;

   localparam logic [2:0] FAULT_NONE    = 3'd0;
   localparam logic [2:0] FAULT_ILLEGAL = 3'd1;
   localparam logic [2:0] FAULT_NACK    = 3'd2;
   localparam logic [2:0] FAULT_TIMEOUT = 3'd3;

   localparam int OP_HI   = 31;
   localparam int OP_LO   = 24;
   localparam int DEV_HI  = 23;
   localparam int DEV_LO  = 16;
   localparam int REG_HI  = 15;
   localparam int REG_LO  = 8;
   localparam int DATA_HI = 7;
   localparam int DATA_LO = 0;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational field split and opcode legality check
//
// Purpose: splits an instruction word into its fields and classifies the
// opcode.
// Ports:
//   instr    in  32  instruction word from the register memory
//   dev      out 7   I2C device address (dev[6:0]; dev[7] is ignored)
//   reg_addr out 8   target register
//   data     out 8   write byte
//   is_nop   out 1   opcode is NOP
//   is_read  out 1   opcode is READ
//   legal    out 1   opcode is one of NOP, READ, WRITE

module instr_decode
   import seq_pkg::*;
(
   input  logic [31:0] instr,
   output logic [6:0]  dev,
   output logic [7:0]  reg_addr,
   output logic [7:0]  data,
   output logic        is_nop,
   output logic        is_read,
   output logic        legal
);

   logic [7:0] op;
   logic       is_write;
   // The top bit of the device byte carries no meaning on a 7-bit bus.
   logic       dev_msb_unused;

   assign op             = instr[OP_HI:OP_LO];
   assign dev            = instr[DEV_HI-1:DEV_LO];
   assign dev_msb_unused = instr[DEV_HI];
   assign reg_addr       = instr[REG_HI:REG_LO];
   assign data           = instr[DATA_HI:DATA_LO];

   assign is_nop   = (op == OP_NOP);
   assign is_read  = (op == OP_READ);
   assign is_write = (op == OP_WRITE);
   assign legal    = is_nop | is_read | is_write;

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetches, decodes and executes I2C instruction words
//
// Purpose: walks the register memory from address 0, turning READ/WRITE words
// into I2C master commands and publishing read-back bytes.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   start                 pulse; runs the program from address 0 when idle/halted
//   mem_addr/mem_data/mem_err  register memory fetch port (1-cycle latency)
//   cmd_valid/cmd_ready/cmd_rw/cmd_dev/cmd_reg/cmd_wdata  I2C command
//   rsp_valid/rsp_nack/rsp_rdata                          I2C response
//   result_valid/result_reg/result_data                   read-back byte
//   busy, done, fault     status

module instr_sequencer
   import seq_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int LAST_ADDR      = 255,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data,
   input  logic [3:0]        mem_err,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_rw,
   output logic [6:0]        cmd_dev,
   output logic [7:0]        cmd_reg,
   output logic [7:0]        cmd_wdata,
   input  logic              rsp_valid,
   input  logic              rsp_nack,
   input  logic [7:0]        rsp_rdata,
   output logic              result_valid,
   output logic [7:0]        result_reg,
   output logic [7:0]        result_data,
   output logic              busy,
   output logic              done,
   output logic [2:0]        fault
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LIM  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(LAST_ADDR);

   state_e            state;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0]  tcnt;

   logic [6:0] dec_dev;
   logic [7:0] dec_reg;
   logic [7:0] dec_data;
   logic       dec_nop;
   logic       dec_read;
   logic       dec_legal;

   instr_decode u_decode (
      .instr    (mem_data),
      .dev      (dec_dev),
      .reg_addr (dec_reg),
      .data     (dec_data),
      .is_nop   (dec_nop),
      .is_read  (dec_read),
      .legal    (dec_legal)
   );

   // pc is held between fetches, so the memory sees a stable address for the
   // whole FETCH/WAIT/DECODE window.
   assign mem_addr = pc;
   assign busy     = (state != IDLE) && (state != HALT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         pc           <= '0;
         tcnt         <= '0;
         cmd_valid    <= 1'b0;
         cmd_rw       <= 1'b0;
         cmd_dev      <= '0;
         cmd_reg      <= '0;
         cmd_wdata    <= '0;
         result_valid <= 1'b0;
         result_reg   <= '0;
         result_data  <= '0;
         done         <= 1'b0;
         fault        <= FAULT_NONE;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  done  <= 1'b0;
                  fault <= FAULT_NONE;
                  pc    <= '0;
                  state <= FETCH;
               end
            end

            FETCH: state <= WAIT;

            WAIT: state <= DECODE;

            DECODE: begin
               if (mem_err != 4'd0) begin
                  // Invalid address marks the end of the program.
                  done  <= 1'b1;
                  fault <= FAULT_NONE;
                  state <= HALT;
               end else if (!dec_legal) begin
                  done  <= 1'b0;
                  fault <= FAULT_ILLEGAL;
                  state <= HALT;
               end else if (dec_nop) begin
                  state <= ADVANCE;
               end else begin
                  cmd_valid <= 1'b1;
                  cmd_rw    <= dec_read;
                  cmd_dev   <= dec_dev;
                  cmd_reg   <= dec_reg;
                  cmd_wdata <= dec_data;
                  tcnt      <= '0;
                  state     <= ISSUE;
               end
            end

            ISSUE: begin
               // An accepted command always proceeds to RESP; the counter
               // saturates so the timeout then fires on the first RESP cycle.
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= RESP;
                  if (tcnt != CNT_LIM) tcnt <= tcnt + 1'b1;
               end else if (tcnt == CNT_LIM) begin
                  cmd_valid <= 1'b0;
                  fault     <= FAULT_TIMEOUT;
                  state     <= HALT;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            RESP: begin
               // A response arriving on the last allowed cycle beats the timeout.
               if (rsp_valid) begin
                  if (rsp_nack) begin
                     fault <= FAULT_NACK;
                     state <= HALT;
                  end else begin
                     if (cmd_rw) begin
                        result_valid <= 1'b1;
                        result_reg   <= cmd_reg;
                        result_data  <= rsp_rdata;
                     end
                     state <= ADVANCE;
                  end
               end else if (tcnt == CNT_LIM) begin
                  fault <= FAULT_TIMEOUT;
                  state <= HALT;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            ADVANCE: begin
               if (pc == PC_LAST) begin
                  done  <= 1'b1;
                  state <= HALT;
               end else begin
                  pc    <= pc + 1'b1;
                  state <= FETCH;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer

module tb_instr_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic start_a, start_b;
   logic cmd_ready;
   logic rsp_valid, rsp_nack;
   logic [7:0] rsp_rdata;

   logic [7:0]  mem_addr_a, mem_addr_b;
   logic [31:0] mem_data_a, mem_data_b;
   logic [3:0]  mem_err_a, mem_err_b;
   logic        cmd_valid_a, cmd_valid_b, cmd_rw_a, cmd_rw_b;
   logic [6:0]  cmd_dev_a, cmd_dev_b;
   logic [7:0]  cmd_reg_a, cmd_reg_b, cmd_wdata_a, cmd_wdata_b;
   logic        result_valid_a, result_valid_b;
   logic [7:0]  result_reg_a, result_reg_b, result_data_a, result_data_b;
   logic        busy_a, busy_b, done_a, done_b;
   logic [2:0]  fault_a, fault_b;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       rw;
      logic [6:0] dev;
      logic [7:0] rg;
      logic [7:0] wd;
   } cmd_t;

   typedef struct packed {
      logic [7:0] rg;
      logic [7:0] data;
   } res_t;

   cmd_t exp_cmd[$];
   res_t exp_res[$];
   cmd_t mon_cmd, mon_cmd_want;
   res_t mon_res, mon_res_want;

   logic [31:0] mem [0:255];
   logic [3:0]  err [0:255];
   int          rsp_mode;   // 0 = ack, 1 = nack, 2 = never respond
   logic [7:0]  rsp_byte;

   instr_sequencer dut_a (
      .clk(clk), .reset(reset), .start(start_a),
      .mem_addr(mem_addr_a), .mem_data(mem_data_a), .mem_err(mem_err_a),
      .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw_a),
      .cmd_dev(cmd_dev_a), .cmd_reg(cmd_reg_a), .cmd_wdata(cmd_wdata_a),
      .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
      .result_valid(result_valid_a), .result_reg(result_reg_a), .result_data(result_data_a),
      .busy(busy_a), .done(done_a), .fault(fault_a)
   );

   // Never started while dut_a runs; only the timeout and LAST_ADDR scenarios use it.
   instr_sequencer #(.ADDR_W(8), .LAST_ADDR(3), .TIMEOUT_CYCLES(16)) dut_b (
      .clk(clk), .reset(reset), .start(start_b),
      .mem_addr(mem_addr_b), .mem_data(mem_data_b), .mem_err(mem_err_b),
      .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw_b),
      .cmd_dev(cmd_dev_b), .cmd_reg(cmd_reg_b), .cmd_wdata(cmd_wdata_b),
      .rsp_valid(1'b0), .rsp_nack(1'b0), .rsp_rdata(8'h00),
      .result_valid(result_valid_b), .result_reg(result_reg_b), .result_data(result_data_b),
      .busy(busy_b), .done(done_b), .fault(fault_b)
   );

   // Registered register memory, one read port per sequencer.
   always @(posedge clk) begin
      mem_data_a <= mem[mem_addr_a];
      mem_err_a  <= err[mem_addr_a];
      mem_data_b <= mem[mem_addr_b];
      mem_err_b  <= err[mem_addr_b];
   end

   // Scoreboard: commands and read results of dut_a are compared in order.
   always @(negedge clk) begin
      if (!reset && cmd_valid_a && cmd_ready) begin
         mon_cmd = {cmd_rw_a, cmd_dev_a, cmd_reg_a, cmd_wdata_a};
         total++;
         if (exp_cmd.size() == 0) begin
            bad++;
            $display("FAIL cmd_unexpected got=%h want=none", mon_cmd);
         end else begin
            mon_cmd_want = exp_cmd.pop_front();
            if (mon_cmd !== mon_cmd_want) begin
               bad++;
               $display("FAIL cmd_fields got=%h want=%h", mon_cmd, mon_cmd_want);
            end
         end
      end
      if (!reset && result_valid_a) begin
         mon_res = {result_reg_a, result_data_a};
         total++;
         if (exp_res.size() == 0) begin
            bad++;
            $display("FAIL result_unexpected got=%h want=none", mon_res);
         end else begin
            mon_res_want = exp_res.pop_front();
            if (mon_res !== mon_res_want) begin
               bad++;
               $display("FAIL result_fields got=%h want=%h", mon_res, mon_res_want);
            end
         end
      end
   end

   // I2C responder: answers each accepted dut_a command on the following cycle.
   initial begin
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      rsp_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset && cmd_valid_a && cmd_ready && rsp_mode != 2) begin
            @(posedge clk);
            #1;
            rsp_valid = 1'b1;
            rsp_nack  = (rsp_mode == 1);
            rsp_rdata = rsp_byte;
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            rsp_rdata = 8'h00;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_clear();
      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'h0;
         err[i] = 4'h1;
      end
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
   endtask

   task automatic wait_halt_a(input int limit);
      int n;
      n = 0;
      while (busy_a && n < limit) begin
         tick(1);
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      total++;
      if ({cmd_valid_a, busy_a, done_a, fault_a, result_valid_a, mem_addr_a} !== '0) begin
         bad++;
         $display("FAIL reset_a_status got=%h want=0",
                  {cmd_valid_a, busy_a, done_a, fault_a, result_valid_a, mem_addr_a});
      end
      total++;
      if ({cmd_rw_a, cmd_dev_a, cmd_reg_a, cmd_wdata_a, result_reg_a, result_data_a} !== '0) begin
         bad++;
         $display("FAIL reset_a_fields got=%h want=0",
                  {cmd_rw_a, cmd_dev_a, cmd_reg_a, cmd_wdata_a, result_reg_a, result_data_a});
      end
      total++;
      if ({cmd_valid_b, busy_b, done_b, fault_b, mem_addr_b} !== '0) begin
         bad++;
         $display("FAIL reset_b_status got=%h want=0",
                  {cmd_valid_b, busy_b, done_b, fault_b, mem_addr_b});
      end
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_program();
      load_clear();
      mem[0] = 32'h0100f000; err[0] = 4'h0;
      mem[1] = 32'h021dab32; err[1] = 4'h0;
      cmd_ready = 1'b1;
      rsp_mode  = 0;
      rsp_byte  = 8'h5A;
      exp_cmd.push_back({1'b1, 7'h00, 8'hF0, 8'h00});
      exp_cmd.push_back({1'b0, 7'h1D, 8'hAB, 8'h32});
      exp_res.push_back({8'hF0, 8'h5A});
      pulse_start_a();
      total++;
      if (busy_a !== 1'b1) begin bad++; $display("FAIL prog_busy got=%b want=1", busy_a); end
      wait_halt_a(200);
      total++;
      if (busy_a !== 1'b0) begin bad++; $display("FAIL prog_halt got=busy want=idle"); end
      total++;
      if ({done_a, fault_a} !== {1'b1, 3'd0}) begin
         bad++; $display("FAIL prog_done got=%b/%0d want=1/0", done_a, fault_a);
      end
      total++;
      if (mem_addr_a !== 8'd2) begin bad++; $display("FAIL prog_pc got=%0d want=2", mem_addr_a); end
      total++;
      if (exp_cmd.size() + exp_res.size() !== 0) begin
         bad++; $display("FAIL prog_pending got=%0d want=0", exp_cmd.size() + exp_res.size());
      end
   endtask

   task automatic test_ready_stall();
      int n;
      load_clear();
      mem[0] = 32'h012A1000; err[0] = 4'h0;
      cmd_ready = 1'b0;
      rsp_mode  = 0;
      rsp_byte  = 8'h77;
      exp_cmd.push_back({1'b1, 7'h2A, 8'h10, 8'h00});
      exp_res.push_back({8'h10, 8'h77});
      pulse_start_a();
      n = 0;
      while (!cmd_valid_a && n < 20) begin tick(1); n++; end
      for (int i = 0; i < 20; i++) begin
         total++;
         if ({cmd_valid_a, cmd_rw_a, cmd_dev_a, cmd_reg_a, cmd_wdata_a} !==
             {1'b1, 1'b1, 7'h2A, 8'h10, 8'h00}) begin
            bad++;
            $display("FAIL stall_hold cyc=%0d got=%h want=%h", i,
                     {cmd_valid_a, cmd_rw_a, cmd_dev_a, cmd_reg_a, cmd_wdata_a},
                     {1'b1, 1'b1, 7'h2A, 8'h10, 8'h00});
         end
         tick(1);
      end
      cmd_ready = 1'b1;
      tick(1);
      total++;
      if (cmd_valid_a !== 1'b0) begin bad++; $display("FAIL stall_drop got=%b want=0", cmd_valid_a); end
      wait_halt_a(200);
      total++;
      if ({busy_a, done_a, fault_a} !== {1'b0, 1'b1, 3'd0}) begin
         bad++; $display("FAIL stall_end got=%b%b/%0d want=01/0", busy_a, done_a, fault_a);
      end
      total++;
      if (exp_cmd.size() + exp_res.size() !== 0) begin
         bad++; $display("FAIL stall_pending got=%0d want=0", exp_cmd.size() + exp_res.size());
      end
   endtask

   task automatic test_illegal();
      int  n;
      logic saw;
      load_clear();
      mem[0] = 32'h07000000; err[0] = 4'h0;
      pulse_start_a();
      saw = 1'b0;
      n = 0;
      while (busy_a && n < 50) begin
         if (cmd_valid_a) saw = 1'b1;
         tick(1);
         n++;
      end
      total++;
      if ({busy_a, done_a, fault_a} !== {1'b0, 1'b0, 3'd1}) begin
         bad++; $display("FAIL illegal_status got=%b%b/%0d want=00/1", busy_a, done_a, fault_a);
      end
      total++;
      if (saw !== 1'b0) begin bad++; $display("FAIL illegal_cmd got=%b want=0", saw); end
   endtask

   task automatic test_nack();
      load_clear();
      mem[0] = 32'h00000000; err[0] = 4'h0;
      mem[1] = 32'h01502200; err[1] = 4'h0;
      rsp_mode = 1;
      rsp_byte = 8'hEE;
      exp_cmd.push_back({1'b1, 7'h50, 8'h22, 8'h00});
      pulse_start_a();
      wait_halt_a(200);
      total++;
      if ({busy_a, done_a, fault_a} !== {1'b0, 1'b0, 3'd2}) begin
         bad++; $display("FAIL nack_status got=%b%b/%0d want=00/2", busy_a, done_a, fault_a);
      end
      total++;
      if (mem_addr_a !== 8'd1) begin bad++; $display("FAIL nack_pc got=%0d want=1", mem_addr_a); end
      total++;
      if (exp_cmd.size() !== 0) begin bad++; $display("FAIL nack_pending got=%0d want=0", exp_cmd.size()); end
   endtask

   task automatic test_reset_restart();
      int n;
      load_clear();
      mem[0] = 32'h013C0500; err[0] = 4'h0;
      rsp_mode  = 2;
      cmd_ready = 1'b1;
      exp_cmd.push_back({1'b1, 7'h3C, 8'h05, 8'h00});
      pulse_start_a();
      n = 0;
      while (!cmd_valid_a && n < 20) begin tick(1); n++; end
      tick(3);
      total++;
      if ({busy_a, cmd_valid_a} !== 2'b10) begin
         bad++; $display("FAIL rst_in_resp got=%b%b want=10", busy_a, cmd_valid_a);
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({cmd_valid_a, busy_a, done_a, fault_a, result_valid_a, mem_addr_a, cmd_rw_a,
           cmd_dev_a, cmd_reg_a, cmd_wdata_a} !== '0) begin
         bad++; $display("FAIL rst_async got=%h want=0",
                         {cmd_valid_a, busy_a, done_a, fault_a, result_valid_a, mem_addr_a,
                          cmd_rw_a, cmd_dev_a, cmd_reg_a, cmd_wdata_a});
      end
      tick(1);
      reset = 1'b0;
      load_clear();
      mem[0] = 32'h0; err[0] = 4'h0;
      mem[1] = 32'h0; err[1] = 4'h0;
      rsp_mode = 0;
      pulse_start_a();
      total++;
      if ({busy_a, mem_addr_a} !== {1'b1, 8'd0}) begin
         bad++; $display("FAIL rst_restart got=%b/%0d want=1/0", busy_a, mem_addr_a);
      end
      tick(5);
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      total++;
      if ({busy_a, mem_addr_a} !== {1'b1, 8'd1}) begin
         bad++; $display("FAIL rst_restart_ignored got=%b/%0d want=1/1", busy_a, mem_addr_a);
      end
      wait_halt_a(100);
      total++;
      if ({busy_a, done_a, fault_a, mem_addr_a} !== {1'b0, 1'b1, 3'd0, 8'd2}) begin
         bad++; $display("FAIL rst_rerun_end got=%b%b/%0d/%0d want=01/0/2",
                         busy_a, done_a, fault_a, mem_addr_a);
      end
      total++;
      if (exp_cmd.size() !== 0) begin bad++; $display("FAIL rst_pending got=%0d want=0", exp_cmd.size()); end
   endtask

   task automatic test_timeout();
      load_clear();
      mem[0] = 32'h01001100; err[0] = 4'h0;
      cmd_ready = 1'b1;
      start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
      tick(18);
      total++;
      if ({busy_b, fault_b, cmd_valid_b} !== {1'b1, 3'd0, 1'b0}) begin
         bad++; $display("FAIL timeout_early got=%b/%0d/%b want=1/0/0", busy_b, fault_b, cmd_valid_b);
      end
      tick(1);
      total++;
      if ({busy_b, done_b, fault_b} !== {1'b0, 1'b0, 3'd3}) begin
         bad++; $display("FAIL timeout_fault got=%b%b/%0d want=00/3", busy_b, done_b, fault_b);
      end
   endtask

   task automatic test_last_addr();
      logic [7:0] max_addr;
      load_clear();
      for (int i = 0; i < 4; i++) begin
         mem[i] = 32'h0;
         err[i] = 4'h0;
      end
      start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
      max_addr = mem_addr_b;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         if (mem_addr_b > max_addr) max_addr = mem_addr_b;
      end
      total++;
      if ({busy_b, done_b} !== 2'b10) begin
         bad++; $display("FAIL last_early got=%b%b want=10", busy_b, done_b);
      end
      tick(1);
      total++;
      if ({busy_b, done_b, fault_b, mem_addr_b} !== {1'b0, 1'b1, 3'd0, 8'd3}) begin
         bad++; $display("FAIL last_done got=%b%b/%0d/%0d want=01/0/3", busy_b, done_b, fault_b, mem_addr_b);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1);
         if (mem_addr_b > max_addr) max_addr = mem_addr_b;
      end
      total++;
      if (max_addr > 8'd3) begin bad++; $display("FAIL last_max_addr got=%0d want<=3", max_addr); end
   endtask

   initial begin
      reset     = 1'b1;
      start_a   = 1'b0;
      start_b   = 1'b0;
      cmd_ready = 1'b0;
      rsp_mode  = 2;
      rsp_byte  = 8'h00;
      load_clear();
      test_reset();
      test_program();
      test_ready_stall();
      test_illegal();
      test_nack();
      test_reset_restart();
      test_timeout();
      test_last_addr();
      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Reads the 32-bit instruction words from the register memory, decodes them and executes them as I2C transactions. Each word has the format op[31:24] | dev[23:16] | reg[15:8] | data[7:0].
- Sits between register_memory and the I2C master's command/response interface.
- Publishes read-back bytes to the accelerometer-to-7-seg datapath.

Parameters:
ADDR_W, 8, width of the instruction address; must match the register memory address width.
LAST_ADDR, 255, highest fetchable address; the program ends after executing it.
TIMEOUT_CYCLES, 100000, maximum cycles to wait for an I2C response before faulting.

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
start  in  1  single-cycle pulse; begins execution at address 0 when idle
mem_addr  out  ADDR_W  instruction address presented to the register memory
mem_data  in  32  instruction word; registered, valid 1 cycle after mem_addr is sampled
mem_err  in  4  memory error code; nonzero means the address is invalid (end of program)
cmd_valid  out  1  I2C command valid
cmd_ready  in  1  I2C master accepts the command
cmd_rw  out  1  1 = read, 0 = write
cmd_dev  out  7  I2C device address, taken from dev[6:0]
cmd_reg  out  8  target register
cmd_wdata  out  8  write byte
rsp_valid  in  1  single-cycle pulse: transaction finished
rsp_nack  in  1  qualified by rsp_valid; the device did not acknowledge
rsp_rdata  in  8  qualified by rsp_valid; the byte read
result_valid  out  1  single-cycle pulse on a completed read
result_reg  out  8  register of that read
result_data  out  8  byte read
busy  out  1  high whenever the state is not IDLE or HALT
done  out  1  level; high in HALT after a clean finish
fault  out  3  0 = none, 1 = illegal opcode, 2 = NACK, 3 = timeout

Behaviour:
- Reset (asynchronous): state IDLE, pc = 0, all outputs 0.
- IDLE:
  - start = 1 -> clear done and fault, pc = 0, go to FETCH.
  - start while not IDLE is ignored.
- FETCH: drive mem_addr = pc for 1 cycle -> go to WAIT.
- WAIT: 1 cycle covering the memory latency -> go to DECODE.
- DECODE: sample mem_data and mem_err.
  - mem_err != 0 -> HALT, done = 1, fault = 0.
  - op 0x00 (NOP) -> ADVANCE.
  - op 0x01 (READ) or 0x02 (WRITE): load the cmd_* registers -> go to ISSUE.
  - Any other op -> HALT, fault = 1, done = 0.
- ISSUE:
  - Hold cmd_valid = 1 with stable fields until cmd_ready.
  - The handshake completes on the edge where cmd_valid && cmd_ready; cmd_valid drops the next cycle -> go to RESP.
- RESP:
  - Timeout counter clears on entry to ISSUE and counts every cycle spent in ISSUE or RESP.
  - rsp_valid && rsp_nack -> HALT, fault = 2.
  - rsp_valid && !rsp_nack:
    - On a read, pulse result_valid for 1 cycle with result_reg/result_data registered.
    - Then go to ADVANCE.
  - Counter reaches TIMEOUT_CYCLES - 1 without rsp_valid -> HALT, fault = 3.
  - rsp_valid on the same cycle as the timeout wins over the timeout.
- ADVANCE:
  - pc == LAST_ADDR -> HALT, done = 1.
  - Otherwise pc = pc + 1 -> FETCH.
  - pc never wraps.
- HALT:
  - done and fault are held.
  - A start pulse re-runs from address 0, clearing done and fault.
- Any rsp_valid seen outside RESP is ignored.
- Reset in any state returns to IDLE immediately; no partial command is retried.
- Minimum latency per NOP is 4 cycles (FETCH, WAIT, DECODE, ADVANCE).
- The dev[7] bit is ignored.

Decomposition:
- Package seq_pkg:
  - opcode enum (OP_NOP = 8'h00, OP_READ = 8'h01, OP_WRITE = 8'h02);
  - state enum (IDLE, FETCH, WAIT, DECODE, ISSUE, RESP, ADVANCE, HALT);
  - fault code constants;
  - field bit-position localparams for op/dev/reg/data.
- One natural sub-module, instr_decode: combinational field split plus opcode legality check. Everything else stays in instr_sequencer.

Test Plan:
- Program {0: 0x0100f000, 1: 0x021dab32, 2: mem_err = 1}, start, cmd_ready tied high, read response 0x5A.
  - Cmd 1: cmd_rw = 1, dev 0x00, reg 0xF0; result_valid with result_reg 0xF0 and result_data 0x5A.
  - Cmd 2: cmd_rw = 0, dev 0x1D, reg 0xAB, wdata 0x32.
  - Then done = 1, fault = 0.
- cmd_ready held low for 20 cycles -> cmd_valid and fields stable throughout; exactly one command is accepted.
- Word 0x07000000 at address 0 -> no cmd_valid, fault = 1, done = 0, busy = 0.
- READ instruction with rsp_valid and rsp_nack = 1 -> fault = 2, no result_valid, pc not advanced.
- TIMEOUT_CYCLES = 16, no rsp_valid -> fault = 3 exactly 16 cycles after entering ISSUE.
- Assert reset during RESP, then start -> outputs return to 0, and execution restarts at mem_addr 0. A second start pulse while busy is ignored.
- LAST_ADDR = 3 with four NOPs -> done = 1 after 16 cycles; mem_addr never exceeds 3.
